sdram_frame_arbiter: RTL

- Schedules 512-word burst requests from the camera write FIFO and the VGA read FIFO onto the single `sdram_top` write/read request ports.
- Generates burst addresses for both sides.
- Manages ping-pong frame banks: the camera fills one bank while VGA reads the last completed frame from the other.
- Sits in the `clk_133M` domain between `cam2fifo`/`fifo2vga` and `sdram_top`.

---
 rtl/sdram_frame_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_frame_arbiter.sv
// Burst arbiter between the camera write FIFO and the VGA read FIFO, with ping-pong frame banks.
// Optional `ARB_STATS_EN adds burst totals and a read-underrun counter.
module sdram_frame_arbiter #(
    parameter int BURST_LEN    = 512,
    parameter int FRAME_BURSTS = 750,
    parameter int WR_THRESH    = 512,
    parameter int RD_THRESH    = 512,
    parameter int RD_URGENT    = 128
) (
    input  logic        clk_133M_i,
    input  logic        rst_133i,
    input  logic        wr_frame_start,
    input  logic        rd_frame_start,
    input  logic [10:0] wr_fifo_used,
    input  logic [10:0] rd_fifo_used,
    output logic        wr_sdram_req,
    input  logic        wr_sdram_ack,
    output logic [23:0] wr_sdram_add,
    output logic        rd_sdram_req,
    input  logic        rd_sdram_ack,
    output logic [23:0] rd_sdram_add,
    output logic        frame_ready,
    output logic [1:0]  arb_st
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] wr_burst_total,
    output logic [15:0] rd_burst_total,
    output logic [7:0]  rd_underrun_cnt
`endif
);

    localparam int COL_W = $clog2(BURST_LEN);
    localparam int CNT_W = $clog2(FRAME_BURSTS + 1);
    localparam logic [CNT_W-1:0] FB    = CNT_W'(FRAME_BURSTS);
    localparam logic [CNT_W-1:0] FB_M1 = CNT_W'(FRAME_BURSTS - 1);
    localparam logic [10:0] WR_TH  = 11'(WR_THRESH);
    localparam logic [10:0] RD_TH  = 11'(RD_THRESH);
    localparam logic [10:0] RD_URG = 11'(RD_URGENT);
    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    typedef enum logic [1:0] {IDLE = 2'd0, WR_BUSY = 2'd1, RD_BUSY = 2'd2} arb_state_t;

    arb_state_t       state_q, state_d;
    logic             wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic [23:0]      wr_add_q, wr_add_d, rd_add_q, rd_add_d;
    logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic             ready_bank_q, ready_bank_d, frame_ready_q, frame_ready_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic             wr_active_q, wr_active_d, rd_active_q, rd_active_d;
    logic             last_grant_q, last_grant_d;
    logic             wr_start_q, wr_start_d, rd_start_q, rd_start_d;
    logic             wr_pend_s, rd_pend_s, rd_urgent_s;

    function automatic logic [23:0] burst_addr(input logic bank, input logic [CNT_W-1:0] cnt);
        logic [23:0] a;
        a     = 24'(cnt) << COL_W;
        a[23] = 1'b0;
        a[22] = bank;
        return a;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk_133M_i) begin
        if (rst_133i) begin
            state_q       <= IDLE;
            wr_req_q      <= 1'b0;
            rd_req_q      <= 1'b0;
            wr_add_q      <= 24'd0;
            rd_add_q      <= 24'd0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            ready_bank_q  <= 1'b0;
            frame_ready_q <= 1'b0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            wr_active_q   <= 1'b0;
            rd_active_q   <= 1'b0;
            last_grant_q  <= GRANT_RD;
            wr_start_q    <= 1'b0;
            rd_start_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_req_q      <= wr_req_d;
            rd_req_q      <= rd_req_d;
            wr_add_q      <= wr_add_d;
            rd_add_q      <= rd_add_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            ready_bank_q  <= ready_bank_d;
            frame_ready_q <= frame_ready_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            wr_active_q   <= wr_active_d;
            rd_active_q   <= rd_active_d;
            last_grant_q  <= last_grant_d;
            wr_start_q    <= wr_start_d;
            rd_start_q    <= rd_start_d;
        end
    end

    // Next-state logic: frame-start application, arbitration and burst completion.
    always_comb begin
        state_d       = state_q;
        wr_req_d      = wr_req_q;
        rd_req_d      = rd_req_q;
        wr_add_d      = wr_add_q;
        rd_add_d      = rd_add_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        ready_bank_d  = ready_bank_q;
        frame_ready_d = frame_ready_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        wr_active_d   = wr_active_q;
        rd_active_d   = rd_active_q;
        last_grant_d  = last_grant_q;
        wr_start_d    = wr_start_q | wr_frame_start;
        rd_start_d    = rd_start_q | rd_frame_start;
        wr_pend_s     = wr_active_q & (wr_fifo_used >= WR_TH) & (wr_cnt_q < FB);
        rd_pend_s     = rd_active_q & (rd_fifo_used <= RD_TH) & (rd_cnt_q < FB);
        rd_urgent_s   = rd_fifo_used < RD_URG;

        case (state_q)
            IDLE: begin
                // Pending frame starts take this IDLE cycle; arbitration resumes on the next one.
                if (wr_start_q || rd_start_q) begin
                    if (wr_start_q) begin
                        wr_start_d  = wr_frame_start;
                        wr_cnt_d    = '0;
                        wr_active_d = 1'b1;
                        if ((wr_cnt_q == FB) && !(rd_active_q && (rd_bank_q == ~wr_bank_q))) begin
                            wr_bank_d = ~wr_bank_q;
                        end else begin
                            wr_bank_d = wr_bank_q;
                        end
                    end else begin
                        wr_start_d = wr_start_q | wr_frame_start;
                    end
                    if (rd_start_q) begin
                        rd_start_d  = rd_frame_start;
                        rd_cnt_d    = '0;
                        rd_bank_d   = ready_bank_q;
                        rd_active_d = frame_ready_q;
                    end else begin
                        rd_start_d = rd_start_q | rd_frame_start;
                    end
                end else if (rd_pend_s && (!wr_pend_s || rd_urgent_s || (last_grant_q == GRANT_WR))) begin
                    state_d      = RD_BUSY;
                    rd_req_d     = 1'b1;
                    rd_add_d     = burst_addr(rd_bank_q, rd_cnt_q);
                    last_grant_d = GRANT_RD;
                end else if (wr_pend_s) begin
                    state_d      = WR_BUSY;
                    wr_req_d     = 1'b1;
                    wr_add_d     = burst_addr(wr_bank_q, wr_cnt_q);
                    last_grant_d = GRANT_WR;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_BUSY: begin
                if (wr_sdram_ack) begin
                    state_d  = IDLE;
                    wr_req_d = 1'b0;
                    if (wr_cnt_q < FB) begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q;
                    end
                    if (wr_cnt_q == FB_M1) begin
                        ready_bank_d  = wr_bank_q;
                        frame_ready_d = 1'b1;
                    end else begin
                        frame_ready_d = frame_ready_q;
                    end
                end else begin
                    wr_req_d = 1'b1;
                end
            end
            RD_BUSY: begin
                if (rd_sdram_ack) begin
                    state_d  = IDLE;
                    rd_req_d = 1'b0;
                    if (rd_cnt_q < FB) begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q;
                    end
                end else begin
                    rd_req_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
            end
        endcase
    end

    assign wr_sdram_req = wr_req_q;
    assign rd_sdram_req = rd_req_q;
    assign wr_sdram_add = wr_add_q;
    assign rd_sdram_add = rd_add_q;
    assign frame_ready  = frame_ready_q;
    assign arb_st       = state_q;

`ifdef ARB_STATS_EN
    logic [15:0] wr_total_q, rd_total_q;
    logic [7:0]  underrun_q;

    // Statistics: accepted bursts (wrapping) and reader frame restarts before completion (saturating).
    always_ff @(posedge clk_133M_i) begin
        if (rst_133i) begin
            wr_total_q <= 16'd0;
            rd_total_q <= 16'd0;
            underrun_q <= 8'd0;
        end else begin
            if ((state_q == WR_BUSY) && wr_sdram_ack) begin
                wr_total_q <= wr_total_q + 16'd1;
            end
            if ((state_q == RD_BUSY) && rd_sdram_ack) begin
                rd_total_q <= rd_total_q + 16'd1;
            end
            if (rd_frame_start && rd_active_q && (rd_cnt_q < FB) && (underrun_q != 8'd255)) begin
                underrun_q <= underrun_q + 8'd1;
            end
        end
    end

    assign wr_burst_total  = wr_total_q;
    assign rd_burst_total  = rd_total_q;
    assign rd_underrun_cnt = underrun_q;
`endif

endmodule
